// File: rtl/rcs_pipe.sv
// Pipelined ripple-carry add/subtract: one SEG-bit segment per stage, registered carries between stages.
// Optional saturation on signed overflow when RCS_PIPE_SAT_EN is defined.
module rcs_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int NSTG = WIDTH / SEG;

    generate
        if (SEG < 1 || (WIDTH % SEG) != 0 || NSTG < 1) begin : g_bad_params
            $error("rcs_pipe: WIDTH must be a non-zero multiple of SEG");
        end
    endgenerate

    // vld[k] qualifies the stage-k input registers; vld[NSTG] is the output register.
    logic [NSTG:0]    vld;
    logic [WIDTH-1:0] a_r   [NSTG];
    logic [WIDTH-1:0] b_r   [NSTG];
    logic [WIDTH-1:0] res_r [NSTG];
    logic [NSTG-1:0]  cin_r;
    logic [WIDTH-1:0] res_nxt [NSTG];
    logic [NSTG-1:0]  cout;

    logic             adv;
    logic [WIDTH-1:0] sum;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic [WIDTH-1:0] final_res;

    assign adv       = !vld[NSTG] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NSTG];

    // Partial results carry only the finished lower segments, so OR-ing in the new one is enough.
    generate
        for (genvar k = 0; k < NSTG; k++) begin : g_stage
            logic [SEG:0] seg_sum;
            assign seg_sum    = {1'b0, a_r[k][k*SEG +: SEG]}
                              + {1'b0, b_r[k][k*SEG +: SEG]}
                              + {{SEG{1'b0}}, cin_r[k]};
            assign cout[k]    = seg_sum[SEG];
            assign res_nxt[k] = res_r[k] | (WIDTH'(seg_sum[SEG-1:0]) << (k * SEG));
        end
    endgenerate

    assign sum   = res_nxt[NSTG-1];
    assign a_msb = a_r[NSTG-1][WIDTH-1];
    assign b_msb = b_r[NSTG-1][WIDTH-1];
    assign ovf   = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);

`ifdef RCS_PIPE_SAT_EN
    assign final_res = !ovf ? sum
                     : (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign final_res = sum;
`endif

    // Whole pipeline, including the output register, moves only when the output can advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            cin_r     <= '0;
            out_res   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else if (adv) begin
            vld      <= {vld[NSTG-1:0], in_valid};
            a_r[0]   <= in_a;
            b_r[0]   <= in_sub ? ~in_b : in_b;
            res_r[0] <= '0;
            cin_r[0] <= in_sub;
            for (int k = 1; k < NSTG; k++) begin
                a_r[k]   <= a_r[k-1];
                b_r[k]   <= b_r[k-1];
                res_r[k] <= res_nxt[k-1];
                cin_r[k] <= cout[k-1];
            end
            out_res   <= final_res;
            out_carry <= cout[NSTG-1];
            out_ovf   <= ovf;
        end
    end

endmodule

// File: tb/tb_rcs_pipe.sv
// Directed and streamed checks of rcs_pipe at WIDTH=32, SEG=8 (4-cycle latency).
// Honours RCS_PIPE_SAT_EN the same way the design does.
module tb_rcs_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_carry;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;

    rcs_pipe #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: {carry, ovf, res}, built from a plain 33-bit sum.
    function automatic logic [33:0] ref_model(input logic sub, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bx;
        logic [32:0] full;
        logic [31:0] res;
        logic        ovf;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
        res  = full[31:0];
        ovf  = (a[31] == bx[31]) && (res[31] != a[31]);
`ifdef RCS_PIPE_SAT_EN
        if (ovf) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {full[32], ovf, res};
    endfunction

    task automatic apply_stimulus(input logic sub, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready_before_beat", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_sub   = sub;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits (bounded) for the result of the beat just accepted and checks latency and values.
    task automatic check_output(input string tag, input logic [31:0] exp_res,
                                input logic exp_carry, input logic exp_ovf);
        int lat;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_res"}, {32'd0, out_res}, {32'd0, exp_res});
        check({tag, "_carry"}, {63'd0, out_carry}, {63'd0, exp_carry});
        check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, exp_ovf});
    endtask

    logic [33:0] exp_q[$];
    logic [31:0] st_a [16];
    logic [31:0] st_b [16];
    logic        st_sub [16];

    initial begin
        int          sent;
        int          got;
        int          cyc;
        logic        prev_stall;
        logic [33:0] prev_out;
        logic        saw_valid;
        logic [33:0] exp_val;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset for two cycles, then confirm quiet outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_res", {32'd0, out_res}, 64'd0);
        check("rst_out_carry", {63'd0, out_carry}, 64'd0);
        check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 saw_valid |= out_valid;
        end
        check("rst_idle_no_valid", {63'd0, saw_valid}, 64'd0);

        $display("[TB] directed add/sub vectors");
        apply_stimulus(1'b1, 32'h0000_0005, 32'h0000_0003);
        check_output("sub_5_3", 32'h0000_0002, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0003, 32'h0000_0005);
        check_output("sub_3_5", 32'hFFFF_FFFE, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0000_00FF, 32'h0000_0001);
        check_output("add_ff_1", 32'h0000_0100, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        check_output("add_max_1", 32'h0000_0000, 1'b1, 1'b0);
`ifdef RCS_PIPE_SAT_EN
        apply_stimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        check_output("add_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'h8000_0000, 32'h0000_0001);
        check_output("sub_ovf", 32'h8000_0000, 1'b1, 1'b1);
`else
        apply_stimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        check_output("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'h8000_0000, 32'h0000_0001);
        check_output("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        @(posedge clk);
        #1;

        $display("[TB] streaming 16 mixed beats with random back-pressure");
        for (int i = 0; i < 16; i++) begin
            st_a[i]   = $urandom;
            st_b[i]   = $urandom;
            st_sub[i] = 1'($urandom_range(1));
        end
        st_a[3] = 32'h7FFF_FFF0; st_b[3] = 32'h0000_0100; st_sub[3] = 1'b0;
        st_a[7] = 32'h8000_0002; st_b[7] = 32'h0000_0010; st_sub[7] = 1'b1;
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        for (cyc = 0; cyc < 300 && got < 16; cyc++) begin
            if (prev_stall) begin
                check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold_outputs", {30'd0, out_carry, out_ovf, out_res}, {30'd0, prev_out});
            end
            out_ready = 1'($urandom_range(1));
            if (sent < 16) begin
                in_valid = 1'b1;
                in_sub   = st_sub[sent];
                in_a     = st_a[sent];
                in_b     = st_b[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                check("stream_result", {30'd0, out_carry, out_ovf, out_res}, {30'd0, exp_val});
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(st_sub[sent], st_a[sent], st_b[sent]));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_carry, out_ovf, out_res};
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_results", 64'(got), 64'd16);
        check("stream_nothing_extra", 64'(exp_q.size()), 64'd0);
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sub   = 1'b0;
            in_a     = 32'(i + 10);
            in_b     = 32'd1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 saw_valid |= out_valid;
        end
        check("midrst_no_valid", {63'd0, saw_valid}, 64'd0);
        apply_stimulus(1'b0, 32'h1234_5678, 32'h1111_1111);
        check_output("post_rst_add", 32'h2345_6789, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
